// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the byte-enable dual-port RAM.
package ram_pkg;

    // Clear sequencer states: sweeping zeros, or open for host traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    // Number of byte-enable lanes in a data word.
    function automatic int unsigned num_bytes(input int unsigned data_w,
                                              input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

    // Legal parameter combination: whole lanes and a 1- or 2-stage read pipe.
    function automatic bit params_ok(input int unsigned data_w,
                                     input int unsigned byte_w,
                                     input int unsigned read_lat);
        return ((data_w % byte_w) == 0) && ((read_lat == 1) || (read_lat == 2));
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset zero-sweep sequencer: walks every address once, then goes ready.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned AddrBitWidth = 8,
    parameter int unsigned ClearOnReset = 1
) (
    input  logic                    clk1,
    input  logic                    rst,
    output logic                    busy,
    output logic                    clr_we,
    output logic [AddrBitWidth-1:0] clr_addr
);

    localparam logic [AddrBitWidth-1:0] LastAddr = '1;
    localparam bit ClearEn = (ClearOnReset != 0);
    localparam clr_state_e EntryState = ClearEn ? CLEAR : READY;

    clr_state_e              state, state_nxt;
    logic [AddrBitWidth-1:0] cnt, cnt_nxt;
    logic                    busy_q;

    // Next state: step the counter while clearing, leave after the last address.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + AddrBitWidth'(1);
                if (cnt == LastAddr) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = EntryState;
        endcase
    end

    // State, counter and registered busy flag.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state  <= EntryState;
            cnt    <= '0;
            busy_q <= ClearEn;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= (state_nxt == CLEAR);
        end
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_dual_be.sv
// Simple dual-port RAM: byte-enable write port, write-first pipelined read port,
// zero-cleared by an internal sweep after reset.
module ram_dual_be
    import ram_pkg::*;
#(
    parameter int unsigned DataDepth    = 32,
    parameter int unsigned AddrBitWidth = 8,
    parameter int unsigned ByteWidth    = 8,
    parameter int unsigned ReadLatency  = 1,
    parameter int unsigned ClearOnReset = 1
) (
    input  logic                              clk1,
    input  logic                              rst,
    input  logic                              we,
    input  logic [DataDepth/ByteWidth-1:0]    be,
    input  logic [AddrBitWidth-1:0]           addr_in,
    input  logic [DataDepth-1:0]              d,
    input  logic                              re,
    input  logic [AddrBitWidth-1:0]           addr_out,
    output logic [DataDepth-1:0]              q,
    output logic                              q_valid,
    output logic                              busy
);

    localparam int unsigned NumBytes = num_bytes(DataDepth, ByteWidth);
    localparam int unsigned Depth    = 1 << AddrBitWidth;

    if (!params_ok(DataDepth, ByteWidth, ReadLatency)) begin : g_bad_params
        $error("ram_dual_be: DataDepth must be a multiple of ByteWidth and ReadLatency 1 or 2");
    end

    logic                    clr_we;
    logic [AddrBitWidth-1:0] clr_addr;
    logic                    host_wr, host_rd;
    logic                    wr_en;
    logic [AddrBitWidth-1:0] wr_addr;
    logic [NumBytes-1:0]     wr_be;
    logic [DataDepth-1:0]    wr_data;
    logic [DataDepth-1:0]    rd_word;
    logic [DataDepth-1:0]    s1_data;
    logic                    s1_valid;
    logic [DataDepth-1:0]    mem [Depth];

    ram_clear_seq #(
        .AddrBitWidth (AddrBitWidth),
        .ClearOnReset (ClearOnReset)
    ) u_clear_seq (
        .clk1     (clk1),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign host_wr = we & ~busy;
    assign host_rd = re & ~busy;

    // Write-port mux: the clear sweep owns the port while busy.
    always_comb begin
        wr_en   = host_wr;
        wr_addr = addr_in;
        wr_be   = be;
        wr_data = d;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_be   = '1;
            wr_data = '0;
        end
    end

    // Memory array with per-lane write; contents are deliberately not reset.
    always_ff @(posedge clk1) begin
        if (wr_en) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*ByteWidth +: ByteWidth] <= wr_data[i*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    // Write-first bypass: enabled lanes of a same-address write replace stored data.
    always_comb begin
        rd_word = mem[addr_out];
        if (host_wr && (addr_in == addr_out)) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (be[i]) begin
                    rd_word[i*ByteWidth +: ByteWidth] = d[i*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    // Stage 1: capture the word at acceptance; data holds between reads.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= host_rd;
            if (host_rd) begin
                s1_data <= rd_word;
            end
        end
    end

    if (ReadLatency == 1) begin : g_lat1
        assign q       = s1_data;
        assign q_valid = s1_valid;
    end else begin : g_lat2
        logic [DataDepth-1:0] s2_data;
        logic                 s2_valid;

        // Stage 2: forward only valid stage-1 words so q holds otherwise.
        always_ff @(posedge clk1 or posedge rst) begin
            if (rst) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign q       = s2_data;
        assign q_valid = s2_valid;
    end

endmodule

// File: tb/tb_ram_dual_be.sv
// Self-checking bench: latency-1 and latency-2 instances share one stimulus
// stream and are compared every cycle against an array/queue model.
`timescale 1ns/1ps
module tb_ram_dual_be;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 16;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          we, re;
    logic [NB-1:0] be;
    logic [AW-1:0] addr_in, addr_out;
    logic [DW-1:0] d;
    logic [DW-1:0] q1, q2;
    logic          qv1, qv2, busy1, busy2;

    always #5 clk1 = ~clk1;

    ram_dual_be #(.DataDepth(DW), .AddrBitWidth(AW), .ByteWidth(8),
                  .ReadLatency(1), .ClearOnReset(1)) u_l1 (
        .clk1(clk1), .rst(rst), .we(we), .be(be), .addr_in(addr_in), .d(d),
        .re(re), .addr_out(addr_out), .q(q1), .q_valid(qv1), .busy(busy1));

    ram_dual_be #(.DataDepth(DW), .AddrBitWidth(AW), .ByteWidth(8),
                  .ReadLatency(2), .ClearOnReset(1)) u_l2 (
        .clk1(clk1), .rst(rst), .we(we), .be(be), .addr_in(addr_in), .d(d),
        .re(re), .addr_out(addr_out), .q(q2), .q_valid(qv2), .busy(busy2));

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory image, busy countdown, queues of due read results.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] mmem [DEPTH];
    int            busy_left = DEPTH;
    int            edge_n = 0;
    logic [DW-1:0] eq1 = '0, eq2 = '0;
    logic          eqv1 = 1'b0, eqv2 = 1'b0;
    pend_t         pq1[$], pq2[$];
    bit            chk_en = 1'b0;

    always @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            busy_left = DEPTH;
            eq1 = '0; eq2 = '0; eqv1 = 1'b0; eqv2 = 1'b0;
            pq1.delete(); pq2.delete();
        end else begin
            logic [DW-1:0] w;
            edge_n++;
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (re) begin
                    w = mmem[addr_out];
                    if (we && addr_in == addr_out)
                        for (int i = 0; i < NB; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
                    pq1.push_back('{due: edge_n,     data: w});
                    pq2.push_back('{due: edge_n + 1, data: w});
                end
                if (we)
                    for (int i = 0; i < NB; i++) if (be[i]) mmem[addr_in][i*8 +: 8] = d[i*8 +: 8];
            end
            eqv1 = 1'b0;
            if (pq1.size() > 0 && pq1[0].due == edge_n) begin
                eq1 = pq1[0].data; eqv1 = 1'b1; void'(pq1.pop_front());
            end
            eqv2 = 1'b0;
            if (pq2.size() > 0 && pq2[0].due == edge_n) begin
                eq2 = pq2[0].data; eqv2 = 1'b1; void'(pq2.pop_front());
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk1) begin
        if (chk_en) begin
            check1 ("busy_l1", busy1, busy_left > 0);
            check1 ("busy_l2", busy2, busy_left > 0);
            check1 ("qv_l1",   qv1,   eqv1);
            check1 ("qv_l2",   qv2,   eqv2);
            check32("q_l1",    q1,    eq1);
            check32("q_l2",    q2,    eq2);
        end
    end

    task automatic cycle();
        @(posedge clk1);
        #1;
    endtask

    // Release reset and measure how long busy stays high (bounded).
    task automatic release_and_count(input string name);
        int n;
        rst = 1'b0;
        n = 0;
        while (busy1 && n < 64) begin
            cycle();
            n++;
        end
        check32(name, DW'(n), DW'(DEPTH));
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0; be = '0;
        addr_in = '0; addr_out = '0; d = '0;
        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        check1 ("rst_busy",  busy1, 1'b1);
        check1 ("rst_qv_l1", qv1,   1'b0);
        check1 ("rst_qv_l2", qv2,   1'b0);
        check32("rst_q_l1",  q1,    '0);
        check32("rst_q_l2",  q2,    '0);
        cycle(); cycle();
        release_and_count("clear_len_first");

        // Preload a nonzero pattern that the next sweep must erase.
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; be = 4'hF; addr_in = AW'(i); d = 32'hA5A5_0000 | DW'(i);
            cycle();
        end
        we = 1'b0;

        // Reset, then a second reset at sweep count 7 with host traffic during busy.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (7) cycle();
        #2 rst = 1'b1;
        #1 check1("midsweep_busy", busy1, 1'b1);
        cycle();
        we = 1'b1; be = 4'hF; addr_in = 4'd3; d = 32'hFFFF_FFFF;
        re = 1'b1; addr_out = 4'd3;
        release_and_count("clear_len_restart");
        we = 1'b0; re = 1'b0;

        // Every address reads back zero.
        for (int i = 0; i < DEPTH; i++) begin
            re = 1'b1; addr_out = AW'(i);
            cycle();
            check1 ("sweep_qv", qv1, 1'b1);
            check32("sweep_zero", q1, 32'h0);
        end
        re = 1'b0;
        cycle(); cycle();

        // Byte-lane merge.
        we = 1'b1; be = 4'b1111; addr_in = 4'd5; d = 32'hAABB_CCDD;
        cycle();
        be = 4'b0101; d = 32'h1122_3344;
        cycle();
        we = 1'b0; re = 1'b1; addr_out = 4'd5;
        cycle();
        re = 1'b0;
        check32("lanes_l1", q1, 32'hAA22_CC44);
        cycle();
        check32("lanes_l2", q2, 32'hAA22_CC44);
        cycle();

        // Read-during-write, write-first on enabled lanes only.
        we = 1'b1; be = 4'b0011; addr_in = 4'd9; d = 32'hDEAD_BEEF;
        re = 1'b1; addr_out = 4'd9;
        cycle();
        we = 1'b0; re = 1'b0;
        check1 ("rdw_qv_l1", qv1, 1'b1);
        check32("rdw_l1",    q1,  32'h0000_BEEF);
        cycle();
        check32("rdw_l2",    q2,  32'h0000_BEEF);
        cycle();

        // Streaming reads with trailing writes to the address just read.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; be = 4'hF; addr_in = AW'(i); d = DW'(i);
            cycle();
        end
        we = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            re = 1'b1; addr_out = AW'(i);
            we = (i > 0); be = 4'hF; addr_in = AW'(i - 1); d = 32'hF000_0000 | DW'(i);
            cycle();
            if (i == 0) begin
                check1("stream_qv_early", qv2, 1'b0);
            end else begin
                check1 ("stream_qv", qv2, 1'b1);
                check32("stream_q",  q2,  DW'(i - 1));
            end
        end
        re = 1'b0; we = 1'b0;
        cycle();
        check1 ("stream_qv_last", qv2, 1'b1);
        check32("stream_q_last",  q2,  32'd7);
        cycle();
        check1 ("stream_qv_end",  qv2, 1'b0);

        // Reset with a read in flight.
        re = 1'b1; addr_out = 4'd4;
        cycle();
        re = 1'b0;
        #2 rst = 1'b1;
        #1;
        check1 ("midread_qv_l1", qv1, 1'b0);
        check1 ("midread_qv_l2", qv2, 1'b0);
        check32("midread_q_l1",  q1,  32'h0);
        check32("midread_q_l2",  q2,  32'h0);
        cycle();
        release_and_count("clear_len_midread");
        re = 1'b1; addr_out = 4'd4;
        cycle();
        re = 1'b0;
        cycle(); cycle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_dual_be.md
# ram_dual_be

Parametrised simple dual-port RAM: one write port with per-byte enables, one synchronous read port with a configurable output pipeline and a read-valid flag. Memory contents are zero-cleared after reset by an internal sweep sequencer. Read-during-write to the same address returns the newly written data. It replaces ad-hoc asynchronous-read buffers in datapath and packet-staging logic, and sits between a single producer and a single consumer on the same clock.

## Interface
- DataDepth, 32, data word width in bits; must be a multiple of ByteWidth
- AddrBitWidth, 8, address width; memory holds 2**AddrBitWidth words
- ByteWidth, 8, bits per write-enable lane; NumBytes = DataDepth/ByteWidth
- ReadLatency, 1, read pipeline depth; legal values 1 or 2
- ClearOnReset, 1, 1 = zero-sweep the memory after reset; 0 = no sweep

- clk1  in  1  single clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write strobe
- be  in  NumBytes  byte-lane write enables; lane i covers d[i*ByteWidth +: ByteWidth]
- addr_in  in  AddrBitWidth  write address
- d  in  DataDepth  write data
- re  in  1  read strobe
- addr_out  in  AddrBitWidth  read address
- q  out  DataDepth  read data, registered
- q_valid  out  1  q holds the data for a read accepted ReadLatency cycles earlier
- busy  out  1  clear sweep in progress; host accesses are ignored

## Operation
- Clear FSM, two states:
  - CLEAR: a sweep counter writes 0 to address cnt every cycle. cnt runs 0 .. 2**AddrBitWidth-1. After the last address, the FSM moves to READY. busy=1.
  - READY: busy=0 and host accesses are accepted.
- Reset entry: CLEAR with cnt=0 if ClearOnReset=1, otherwise READY.
- Write: in READY, when we=1, for each lane i with be[i]=1, mem[addr_in] lane i <= d lane i. Other lanes are unchanged. we=1 with be=0 is a no-op.
- Read: in READY, when re=1, the read of addr_out is accepted. The stage-1 register captures the word.
- Read-during-write to the same address in the same cycle (write-first):
  - enabled lanes return d;
  - disabled lanes return the prior contents.
- Writes to other addresses never disturb reads in flight.
- In CLEAR, we and re are ignored: no memory update and no q_valid.
- Memory array is not reset. Only the FSM, the counter, q, q_valid and the pipeline registers are reset.
- q holds its last value when q_valid=0.

## Timing
- Reset values:
  - q=0, q_valid=0.
  - busy=1 while rst is asserted and afterwards if ClearOnReset=1; busy=0 if ClearOnReset=0.
  - cnt=0; FSM in its entry state.
- Clear duration: busy=1 for exactly 2**AddrBitWidth cycles after rst deasserts. The first host access is accepted in the cycle busy reads 0.
- Read latency:
  - ReadLatency=1: re in cycle t gives q and q_valid=1 in cycle t+1.
  - ReadLatency=2: re in cycle t gives q and q_valid=1 in cycle t+2.
- Data is sampled at acceptance (cycle t). A write to the same address in cycle t+1 does not alter a ReadLatency=2 result already in flight.
- Throughput: one read and one write per cycle, back-to-back, any address pattern.
- q_valid is a per-read pulse, high for one cycle per accepted read.
- Reset mid-sweep or mid-read:
  - The sweep restarts at address 0.
  - Pipeline valids clear immediately (asynchronously).
  - Reads in flight are discarded.

## Structure
- Package ram_pkg holds:
  - the clear-FSM state enum (CLEAR, READY);
  - a function returning NumBytes;
  - elaboration checks: DataDepth % ByteWidth == 0 and ReadLatency in {1,2}.
- Sub-module ram_clear_seq holds the FSM, the sweep counter and busy. It outputs a clear write enable and a clear address, which are muxed ahead of the host write port.
- Memory array, byte-lane write, bypass merge and output pipeline stay in the top module.

## Test plan
- Clear sweep:
  - Stimulus: ClearOnReset=1, AddrBitWidth=4, memory pre-loaded with a nonzero pattern in a prior run, then rst pulsed.
  - Required: busy=1 for 16 cycles. After the sweep, reads of all 16 addresses return 0 with q_valid=1.
- Byte lanes:
  - Stimulus: write 0xAABBCCDD, be=4'b1111, to address 5; then d=0x11223344, be=4'b0101, to address 5; then read address 5.
  - Required: q=0xAA22CC44.
- Read-during-write:
  - Stimulus: address 9 holds 0x00000000; same cycle, we=1, be=4'b0011, d=0xDEADBEEF, re=1, addr_out=9.
  - Required: q=0x0000BEEF, one cycle later for ReadLatency=1.
- Latency and streaming:
  - Stimulus: ReadLatency=2, back-to-back re for addresses 0..7 holding values equal to their address.
  - Required: q_valid high for 8 consecutive cycles starting 2 cycles after the first re; q=0..7 in order.
- Ignore during busy:
  - Stimulus: we=1 to address 3 with d=0xFFFFFFFF, and re=1, both while busy=1.
  - Required: no q_valid pulse; address 3 reads 0 after the sweep.
- Reset mid-operation:
  - Stimulus: assert rst at sweep count 7, and separately with a ReadLatency=2 read in flight.
  - Required: q_valid=0 and q=0 immediately; busy stays 1 for a full 2**AddrBitWidth cycles after release.
